exec_stage: RTL and testbench

//  ID->EX->MEM execute stage of the LEG core. Accepts one decoded instruction per cycle over a

---
 rtl/exec_stage_pkg.sv | 15 +
 rtl/exec_stage_alu.sv | 30 +++
 rtl/exec_stage_branch_cmp.sv | 19 +
 rtl/exec_stage.sv | 102 ++++++++++
 tb/tb_exec_stage.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_stage_pkg.sv
// exec_stage_pkg: operation, operand-select, branch and jump encodings shared by the execute stage.
package exec_stage_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;
    typedef enum logic [1:0] {SRC_A_RS1, SRC_A_PC, SRC_A_ZERO} src_a_e;
    typedef enum logic [1:0] {SRC_B_RS2, SRC_B_IMM, SRC_B_FOUR} src_b_e;
    typedef enum logic [2:0] {BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU} br_cond_e;
    typedef enum logic [1:0] {JMP_NONE, JMP_JAL, JMP_JALR} jmp_e;

    function automatic logic is_shift(input logic [3:0] op);
        return op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    endfunction
endpackage

// File: rtl/exec_stage_alu.sv
// exec_stage_alu: combinational integer ALU; unknown op codes produce zero.
module exec_stage_alu
    import exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [3:0]      i_op,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_y
);
    logic [$clog2(XLEN)-1:0] sh;
    always_comb begin
        sh = i_b[$clog2(XLEN)-1:0];
        o_y = '0;
        case (i_op)
            ALU_ADD:  o_y = i_a + i_b;
            ALU_SUB:  o_y = i_a - i_b;
            ALU_SLL:  o_y = i_a << sh;
            ALU_SLT:  o_y = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_y = {{(XLEN-1){1'b0}}, i_a < i_b};
            ALU_XOR:  o_y = i_a ^ i_b;
            ALU_SRL:  o_y = i_a >> sh;
            ALU_SRA:  o_y = $unsigned($signed(i_a) >>> sh);
            ALU_OR:   o_y = i_a | i_b;
            ALU_AND:  o_y = i_a & i_b;
            default:  o_y = '0;
        endcase
    end
endmodule

// File: rtl/exec_stage_branch_cmp.sv
// exec_stage_branch_cmp: evaluates a branch condition on two forwarded operands.
module exec_stage_branch_cmp
    import exec_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_cond,
    output logic            o_taken
);
    always_comb
        o_taken = i_cond == BR_EQ  ? i_a == i_b :
                  i_cond == BR_NE  ? i_a != i_b :
                  i_cond == BR_LT  ? $signed(i_a) <  $signed(i_b) :
                  i_cond == BR_GE  ? $signed(i_a) >= $signed(i_b) :
                  i_cond == BR_LTU ? i_a <  i_b :
                  i_cond == BR_GEU ? i_a >= i_b : 1'b0;
endmodule

// File: rtl/exec_stage.sv
// exec_stage: operand forwarding/selection, ALU, branch/jump resolution and the EX/MEM register.
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_pc,
    input  logic [4:0]      i_rs1_idx,
    input  logic [4:0]      i_rs2_idx,
    input  logic [XLEN-1:0] i_rs1_val,
    input  logic [XLEN-1:0] i_rs2_val,
    input  logic [XLEN-1:0] i_imm,
    input  logic [3:0]      i_alu_op,
    input  logic [1:0]      i_src_a,
    input  logic [1:0]      i_src_b,
    input  logic [2:0]      i_br_cond,
    input  logic [1:0]      i_jump,
    input  logic [4:0]      i_rd,
    input  logic            i_wb_en,
    input  logic            i_fwd_en,
    input  logic [4:0]      i_fwd_rd,
    input  logic [XLEN-1:0] i_fwd_data,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_rs2_val,
    output logic [4:0]      o_rd,
    output logic            o_wb_en,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);
    logic [XLEN-1:0] rs1, rs2, op_a, b_sel, op_b, alu_y, jalr_sum, target;
    logic            taken, redirect, accept;
    logic            valid_q, valid_d, wb_en_q, wb_en_d, redirect_q, redirect_d;
    logic [XLEN-1:0] result_q, result_d, rs2_q, rs2_d, redirect_pc_q, redirect_pc_d;
    logic [4:0]      rd_q, rd_d;

    always_comb begin
        rs1 = i_fwd_en && i_fwd_rd != 5'd0 && i_fwd_rd == i_rs1_idx ? i_fwd_data : i_rs1_val;
        rs2 = i_fwd_en && i_fwd_rd != 5'd0 && i_fwd_rd == i_rs2_idx ? i_fwd_data : i_rs2_val;
        op_a = i_src_a == SRC_A_RS1 ? rs1 : i_src_a == SRC_A_PC ? i_pc : '0;
        b_sel = i_src_b == SRC_B_RS2 ? rs2 : i_src_b == SRC_B_IMM ? i_imm :
                i_src_b == SRC_B_FOUR ? XLEN'(4) : '0;
        op_b = is_shift(i_alu_op) ? {{(XLEN-5){1'b0}}, b_sel[4:0]} : b_sel;
        jalr_sum = rs1 + i_imm;
        target = i_jump == JMP_JALR ? {jalr_sum[XLEN-1:1], 1'b0} : i_pc + i_imm;
        redirect = i_jump == JMP_JAL || i_jump == JMP_JALR || taken;
    end

    exec_stage_alu #(.XLEN(XLEN)) u_alu (.i_op(i_alu_op), .i_a(op_a), .i_b(op_b), .o_y(alu_y));

    exec_stage_branch_cmp #(.XLEN(XLEN)) u_branch_cmp (
        .i_a(rs1), .i_b(rs2), .i_cond(i_br_cond), .o_taken(taken)
    );

    // A stalled register holds every field; a drained one only drops valid.
    always_comb begin
        accept        = i_valid && o_ready && !i_flush;
        valid_d       = accept ? 1'b1 : (i_flush || i_ready) ? 1'b0 : valid_q;
        result_d      = accept ? alu_y : result_q;
        rs2_d         = accept ? rs2 : rs2_q;
        rd_d          = accept ? i_rd : rd_q;
        wb_en_d       = accept ? i_wb_en && i_rd != 5'd0 : wb_en_q;
        redirect_d    = accept ? redirect : redirect_q;
        redirect_pc_d = accept ? target : redirect_pc_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q       <= 1'b0;
            result_q      <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            wb_en_q       <= 1'b0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= RESET_PC;
        end else begin
            valid_q       <= valid_d;
            result_q      <= result_d;
            rs2_q         <= rs2_d;
            rd_q          <= rd_d;
            wb_en_q       <= wb_en_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign o_ready       = !valid_q || i_ready;
    assign o_valid       = valid_q;
    assign o_result      = result_q;
    assign o_rs2_val     = rs2_q;
    assign o_rd          = rd_q;
    assign o_wb_en       = wb_en_q;
    assign o_redirect    = redirect_q;
    assign o_redirect_pc = redirect_pc_q;
endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: scenario tasks drive the execute stage; a scoreboard checks every consumed output.
module tb_exec_stage;
    import exec_stage_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    typedef struct {
        logic [31:0] pc, rs1_val, rs2_val, imm, fwd_data;
        logic [4:0]  rs1_idx, rs2_idx, rd, fwd_rd;
        logic [3:0]  alu_op;
        logic [1:0]  src_a, src_b, jump;
        logic [2:0]  br_cond;
        logic        wb_en, fwd_en;
    } ins_t;

    typedef struct {
        logic [31:0] result, rs2, rpc;
        logic [4:0]  rd;
        logic        wb, redir;
    } exp_t;

    logic        clk, i_rst, i_valid, o_ready, i_wb_en, i_fwd_en, i_flush, o_valid, i_ready;
    logic        o_wb_en, o_redirect;
    logic [31:0] i_pc, i_rs1_val, i_rs2_val, i_imm, i_fwd_data, o_result, o_rs2_val, o_redirect_pc;
    logic [4:0]  i_rs1_idx, i_rs2_idx, i_rd, i_fwd_rd, o_rd;
    logic [3:0]  i_alu_op;
    logic [1:0]  i_src_a, i_src_b, i_jump;
    logic [2:0]  i_br_cond;

    int   tests = 0, fails = 0, cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    exec_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready), .i_pc(i_pc),
        .i_rs1_idx(i_rs1_idx), .i_rs2_idx(i_rs2_idx), .i_rs1_val(i_rs1_val), .i_rs2_val(i_rs2_val),
        .i_imm(i_imm), .i_alu_op(i_alu_op), .i_src_a(i_src_a), .i_src_b(i_src_b),
        .i_br_cond(i_br_cond), .i_jump(i_jump), .i_rd(i_rd), .i_wb_en(i_wb_en),
        .i_fwd_en(i_fwd_en), .i_fwd_rd(i_fwd_rd), .i_fwd_data(i_fwd_data), .i_flush(i_flush),
        .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result), .o_rs2_val(o_rs2_val),
        .o_rd(o_rd), .o_wb_en(o_wb_en), .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!i_rst && o_valid && i_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL scoreboard: unexpected output result=%h rd=%0d", o_result, o_rd);
            end else begin
                mon_e = sb.pop_front();
                if (o_result !== mon_e.result || o_rs2_val !== mon_e.rs2 || o_rd !== mon_e.rd ||
                    o_wb_en !== mon_e.wb || o_redirect !== mon_e.redir ||
                    (mon_e.redir && o_redirect_pc !== mon_e.rpc)) begin
                    fails++;
                    $display("FAIL scoreboard: got res=%h rs2=%h rd=%0d wb=%b redir=%b pc=%h exp res=%h rs2=%h rd=%0d wb=%b redir=%b pc=%h",
                             o_result, o_rs2_val, o_rd, o_wb_en, o_redirect, o_redirect_pc,
                             mon_e.result, mon_e.rs2, mon_e.rd, mon_e.wb, mon_e.redir, mon_e.rpc);
                end
            end
        end
    end

    function automatic ins_t mk(input logic [3:0] op, input logic [1:0] sa, input logic [1:0] sb_,
                                input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
        ins_t t = '{default: '0};
        t.alu_op = op; t.src_a = sa; t.src_b = sb_;
        t.rs1_val = a; t.rs2_val = b; t.imm = imm;
        t.rd = 5'd1; t.wb_en = 1'b1;
        return t;
    endfunction

    function automatic exp_t ex(input logic [31:0] res, input logic [31:0] rs2, input logic [4:0] rd,
                                input logic wb, input logic redir, input logic [31:0] rpc);
        exp_t e;
        e.result = res; e.rs2 = rs2; e.rd = rd; e.wb = wb; e.redir = redir; e.rpc = rpc;
        return e;
    endfunction

    task automatic put(input ins_t t);
        i_pc = t.pc; i_rs1_val = t.rs1_val; i_rs2_val = t.rs2_val; i_imm = t.imm;
        i_rs1_idx = t.rs1_idx; i_rs2_idx = t.rs2_idx; i_rd = t.rd; i_wb_en = t.wb_en;
        i_alu_op = t.alu_op; i_src_a = t.src_a; i_src_b = t.src_b;
        i_br_cond = t.br_cond; i_jump = t.jump;
        i_fwd_en = t.fwd_en; i_fwd_rd = t.fwd_rd; i_fwd_data = t.fwd_data;
    endtask

    task automatic drive(input ins_t t, input exp_t e);
        bit ok = 0;
        put(t);
        i_valid = 1;
        sb.push_back(e);
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = o_ready && !i_flush;
            @(posedge clk);
            #1;
        end
        i_valid = 0;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL accept: o_ready=%b after 50 cycles, required 1", o_ready);
            void'(sb.pop_back());
        end
    endtask

    task automatic drain();
        i_ready = 1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1;
        repeat (2) @(posedge clk);
        #1 i_rst = 0;
        @(negedge clk);
        tests++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_valid: o_valid=%b o_ready=%b required 0/1", o_valid, o_ready);
        end
        tests++;
        if (o_redirect_pc !== RST_PC) begin
            fails++;
            $display("FAIL reset_pc: got %h required %h", o_redirect_pc, RST_PC);
        end
        tests++;
        if (o_result !== 0 || o_rs2_val !== 0 || o_rd !== 0 || o_wb_en !== 0 || o_redirect !== 0) begin
            fails++;
            $display("FAIL reset_data: res=%h rs2=%h rd=%0d wb=%b redir=%b required all 0",
                     o_result, o_rs2_val, o_rd, o_wb_en, o_redirect);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu();
        drive(mk(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 5, 7, 0), ex(12, 7, 1, 1, 0, 0));
        tests++;
        if (o_valid !== 1'b1) begin
            fails++;
            $display("FAIL latency: o_valid=%b one cycle after accept, required 1", o_valid);
        end
        drive(mk(ALU_SRA, SRC_A_RS1, SRC_B_IMM, 32'h8000_0000, 0, 33), ex(32'hC000_0000, 0, 1, 1, 0, 0));
        drive(mk(ALU_SUB, SRC_A_RS1, SRC_B_RS2, 3, 10, 0), ex(32'hFFFF_FFF9, 10, 1, 1, 0, 0));
        drive(mk(ALU_SLT, SRC_A_RS1, SRC_B_RS2, 32'hFFFF_FFFF, 1, 0), ex(1, 1, 1, 1, 0, 0));
        drive(mk(ALU_SLTU, SRC_A_RS1, SRC_B_RS2, 32'hFFFF_FFFF, 1, 0), ex(0, 1, 1, 1, 0, 0));
        drive(mk(ALU_SLL, SRC_A_ZERO, SRC_B_FOUR, 9, 0, 0), ex(0, 0, 1, 1, 0, 0));
        drive(mk(ALU_SRL, SRC_A_RS1, SRC_B_FOUR, 32'hF0, 0, 0), ex(32'hF, 0, 1, 1, 0, 0));
        drain();
    endtask

    task automatic test_forward();
        ins_t t = mk(ALU_OR, SRC_A_RS1, SRC_B_IMM, 0, 0, 0);
        t.rs1_idx = 3; t.fwd_en = 1; t.fwd_rd = 3; t.fwd_data = 32'hAA;
        drive(t, ex(32'hAA, 0, 1, 1, 0, 0));
        t.rs1_idx = 0; t.fwd_rd = 0;
        drive(t, ex(0, 0, 1, 1, 0, 0));
        t.rs1_idx = 3; t.fwd_rd = 3; t.fwd_en = 0; t.rs1_val = 32'h11;
        drive(t, ex(32'h11, 0, 1, 1, 0, 0));
        t = mk(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 1, 1, 0);
        t.rs2_idx = 4; t.fwd_en = 1; t.fwd_rd = 4; t.fwd_data = 32'h55;
        drive(t, ex(32'h56, 32'h55, 1, 1, 0, 0));
        drain();
    endtask

    task automatic test_branch();
        ins_t t = mk(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 32'hFFFF_FFFF, 1, 32'h20);
        t.pc = 32'h100; t.br_cond = BR_LT; t.wb_en = 0; t.rd = 0;
        drive(t, ex(0, 1, 0, 0, 1, 32'h120));
        t.br_cond = BR_LTU;
        drive(t, ex(0, 1, 0, 0, 0, 0));
        t.br_cond = BR_GE;
        drive(t, ex(0, 1, 0, 0, 0, 0));
        t.br_cond = BR_NONE;
        drive(t, ex(0, 1, 0, 0, 0, 0));
        t = mk(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 5, 5, 32'hFFFF_FFF8);
        t.pc = 32'h100; t.br_cond = BR_EQ; t.wb_en = 0; t.rd = 0;
        drive(t, ex(10, 5, 0, 0, 1, 32'hF8));
        drain();
    endtask

    task automatic test_jump();
        ins_t t = mk(ALU_ADD, SRC_A_PC, SRC_B_FOUR, 32'h201, 0, 0);
        t.pc = 32'h40; t.jump = JMP_JALR; t.rd = 5;
        drive(t, ex(32'h44, 0, 5, 1, 1, 32'h200));
        t.rd = 0;
        drive(t, ex(32'h44, 0, 0, 0, 1, 32'h200));
        t.jump = JMP_JAL; t.imm = 32'h10; t.rd = 1;
        drive(t, ex(32'h44, 0, 1, 1, 1, 32'h50));
        drain();
    endtask

    task automatic test_back_to_back();
        int start;
        ins_t t;
        logic [31:0] a, b;
        start = cyc;
        for (int n = 0; n < 4; n++) begin
            a = $urandom; b = $urandom;
            t = mk(n[0] ? ALU_XOR : ALU_ADD, SRC_A_RS1, SRC_B_RS2, a, b, 0);
            t.rd = 5'(n + 2);
            drive(t, ex(n[0] ? a ^ b : a + b, b, 5'(n + 2), 1, 0, 0));
        end
        tests++;
        if (cyc - start != 4) begin
            fails++;
            $display("FAIL throughput: 4 ops took %0d cycles, required 4", cyc - start);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] snap;
        i_ready = 0;
        drive(mk(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 100, 0, 1), ex(101, 0, 1, 1, 0, 0));
        fork
            begin
                drive(mk(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 200, 0, 2), ex(202, 0, 1, 1, 0, 0));
                drive(mk(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 300, 0, 3), ex(303, 0, 1, 1, 0, 0));
            end
            begin
                @(negedge clk);
                snap = o_result;
                repeat (2) begin
                    @(negedge clk);
                    tests++;
                    if (o_ready !== 1'b0 || o_valid !== 1'b1 || o_result !== snap || snap !== 32'd101) begin
                        fails++;
                        $display("FAIL stall_hold: ready=%b valid=%b res=%h required 0/1/%h",
                                 o_ready, o_valid, o_result, 32'd101);
                    end
                end
                @(posedge clk);
                #1 i_ready = 1;
            end
        join
        drain();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL stall_order: %0d entries left, required 0", sb.size());
        end
    endtask

    task automatic test_flush();
        i_ready = 0;
        drive(mk(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 7, 0, 1), ex(8, 0, 1, 1, 0, 0));
        put(mk(ALU_ADD, SRC_A_RS1, SRC_B_IMM, 9, 0, 1));
        i_valid = 1; i_flush = 1;
        @(posedge clk);
        #1 i_flush = 0; i_valid = 0;
        void'(sb.pop_back());
        repeat (2) begin
            @(negedge clk);
            tests++;
            if (o_valid !== 1'b0) begin
                fails++;
                $display("FAIL flush: o_valid=%b, required 0", o_valid);
            end
        end
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic test_reset_mid_stall();
        ins_t t = mk(ALU_ADD, SRC_A_PC, SRC_B_FOUR, 0, 0, 32'h10);
        t.pc = 32'h40; t.jump = JMP_JAL;
        i_ready = 0;
        drive(t, ex(32'h44, 0, 1, 1, 1, 32'h50));
        tests++;
        if (o_valid !== 1'b1 || o_redirect !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: valid=%b redir=%b, required 1/1", o_valid, o_redirect);
        end
        i_rst = 1;
        @(posedge clk);
        #1 i_rst = 0;
        sb.delete();
        tests++;
        if (o_valid !== 1'b0 || o_redirect !== 1'b0 || o_redirect_pc !== RST_PC) begin
            fails++;
            $display("FAIL reset_stall: valid=%b redir=%b pc=%h, required 0/0/%h",
                     o_valid, o_redirect, o_redirect_pc, RST_PC);
        end
        drain();
    endtask

    initial begin
        i_rst = 1; i_valid = 0; i_flush = 0; i_ready = 1;
        put(mk(ALU_ADD, SRC_A_RS1, SRC_B_RS2, 0, 0, 0));
        test_reset();
        test_alu();
        test_forward();
        test_branch();
        test_jump();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid_stall();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL final_drain: %0d entries left, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
